// File: rtl/clock_set_ctrl.sv
// Mode/set controller for a digital clock: cycles RUN -> SET_HR -> SET_MIN on btn_mode,
// issues manual and auto-repeat increments from btn_inc, and gates the seconds tick.
module clock_set_ctrl #(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       auto_inc,
    output logic       min_manual_inc,
    output logic       hr_manual_inc,
    output logic       sec_clear,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] CNT_MAX  = '1;
    localparam logic [HOLD_W-1:0] DELAY_C  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] PERIOD_C = HOLD_W'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        HOLD_IDLE   = 2'b00,
        HOLD_DELAY  = 2'b01,
        HOLD_REPEAT = 2'b10
    } hold_t;

    state_t            r_state, w_state_next;
    hold_t             r_hold, w_hold_next;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next, w_hold_cnt_inc, w_hold_limit;

    logic r_mode_prev, r_inc_prev;
    logic r_auto_inc, r_hr_inc, r_min_inc, r_sec_clear, r_blink;

    logic w_mode_press, w_inc_press, w_manual;
    logic w_auto_inc, w_hr_inc, w_min_inc, w_sec_clear, w_blink;

    assign w_mode_press = btn_mode & ~r_mode_prev;
    assign w_inc_press  = btn_inc  & ~r_inc_prev;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        w_state_next    = r_state;
        w_hold_next     = HOLD_IDLE;
        w_hold_cnt_next = '0;
        w_manual        = 1'b0;
        w_hold_cnt_inc  = (r_hold_cnt == CNT_MAX) ? r_hold_cnt : r_hold_cnt + CNT_ONE;
        w_hold_limit    = (r_hold == HOLD_REPEAT) ? PERIOD_C : DELAY_C;

        if (w_mode_press) begin
            case (r_state)
                ST_RUN:    w_state_next = ST_SET_HR;
                ST_SET_HR: w_state_next = ST_SET_MIN;
                default:   w_state_next = ST_RUN;
            endcase
        end

        // A mode press makes next != current, which drops a coincident inc press.
        if (r_state != ST_RUN && w_state_next == r_state && btn_inc) begin
            if (w_inc_press) begin
                w_hold_next = HOLD_DELAY;
                w_manual    = 1'b1;
            end else if (r_hold != HOLD_IDLE) begin
                if (w_hold_cnt_inc == w_hold_limit) begin
                    w_hold_next = HOLD_REPEAT;
                    w_manual    = 1'b1;
                end else begin
                    w_hold_next     = r_hold;
                    w_hold_cnt_next = w_hold_cnt_inc;
                end
            end
        end

        w_auto_inc  = sec_tick & (w_state_next == ST_RUN);
        w_hr_inc    = w_manual & (r_state == ST_SET_HR);
        w_min_inc   = w_manual & (r_state == ST_SET_MIN);
        w_sec_clear = (r_state == ST_SET_MIN) & (w_state_next == ST_RUN);

        if (w_state_next == ST_RUN) begin
            w_blink = 1'b0;
        end else if (w_state_next != r_state) begin
            w_blink = 1'b1;
        end else begin
            w_blink = r_blink ^ sec_tick;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: history tracks the live level even in reset, so a button held through release is not a press.
        r_mode_prev <= btn_mode;
        r_inc_prev  <= btn_inc;
        if (reset) begin
            r_state     <= ST_RUN;
            r_hold      <= HOLD_IDLE;
            r_hold_cnt  <= '0;
            r_auto_inc  <= 1'b0;
            r_hr_inc    <= 1'b0;
            r_min_inc   <= 1'b0;
            r_sec_clear <= 1'b0;
            r_blink     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hold      <= w_hold_next;
            r_hold_cnt  <= w_hold_cnt_next;
            r_auto_inc  <= w_auto_inc;
            r_hr_inc    <= w_hr_inc;
            r_min_inc   <= w_min_inc;
            r_sec_clear <= w_sec_clear;
            r_blink     <= w_blink;
        end
    end

    assign auto_inc       = r_auto_inc;
    assign hr_manual_inc  = r_hr_inc;
    assign min_manual_inc = r_min_inc;
    assign sec_clear      = r_sec_clear;
    assign mode           = r_state;
    assign blink          = r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: cycle model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_clock_set_ctrl;

    localparam int D = 10;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sec_tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       auto_inc, min_manual_inc, hr_manual_inc, sec_clear, blink;
    logic [1:0] mode;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .REPEAT_DELAY (D),
        .REPEAT_PERIOD(P)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sec_tick      (sec_tick),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .auto_inc      (auto_inc),
        .min_manual_inc(min_manual_inc),
        .hr_manual_inc (hr_manual_inc),
        .sec_clear     (sec_clear),
        .mode          (mode),
        .blink         (blink)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: press count drives a 0/1/2 mode index; hold time is an
    // integer count of cycles since the press, with repeats at D, D+P, D+2P, ...
    int         m_state = 0;
    int         m_hold = -1;
    logic       m_pm = 1'b0, m_pi = 1'b0;
    logic       e_auto = 1'b0, e_min = 1'b0, e_hr = 1'b0, e_clr = 1'b0, e_blink = 1'b0;
    logic [1:0] e_mode = 2'b00;
    logic       model_valid = 1'b0;

    task automatic model_step();
        int   nxt;
        logic mp, ip, pulse;
        mp = btn_mode && !m_pm;
        ip = btn_inc && !m_pi;
        m_pm = btn_mode;
        m_pi = btn_inc;
        if (reset) begin
            m_state = 0;
            m_hold  = -1;
            e_auto  = 1'b0;
            e_min   = 1'b0;
            e_hr    = 1'b0;
            e_clr   = 1'b0;
            e_blink = 1'b0;
        end else begin
            nxt    = mp ? (m_state + 1) % 3 : m_state;
            e_auto = sec_tick && (nxt == 0);
            e_clr  = (m_state == 2) && (nxt == 0);
            pulse  = 1'b0;
            if (m_state != 0 && nxt == m_state && btn_inc) begin
                if (ip) begin
                    m_hold = 0;
                    pulse  = 1'b1;
                end else if (m_hold >= 0) begin
                    m_hold++;
                    if (m_hold >= D && ((m_hold - D) % P) == 0) pulse = 1'b1;
                end
            end else begin
                m_hold = -1;
            end
            e_hr  = pulse && (m_state == 1);
            e_min = pulse && (m_state == 2);
            if (nxt == 0)            e_blink = 1'b0;
            else if (nxt != m_state) e_blink = 1'b1;
            else if (sec_tick)       e_blink = !e_blink;
            m_state = nxt;
        end
        e_mode = m_state[1:0];
        model_valid = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_valid)
            check("cycle_outputs",
                  {25'd0, auto_inc, min_manual_inc, hr_manual_inc, sec_clear, mode, blink},
                  {25'd0, e_auto, e_min, e_hr, e_clr, e_mode, e_blink});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
        step(1);
    endtask

    initial begin
        int cnt_a, cnt_b, cnt_c;
        int hits[$];
        int want[6];
        logic [1:0] seen[3];
        logic clr_on_run;

        // Reset state
        step(3);
        check("reset_outputs",
              {26'd0, auto_inc, min_manual_inc, hr_manual_inc, sec_clear, mode, blink}, 32'd0);
        reset = 1'b0;
        step(2);

        // Three ticks in RUN: one auto_inc each, one cycle later, mode stays 00
        cnt_a = 0;
        for (int i = 0; i < 3; i++) begin
            sec_tick = 1'b1;
            step(1);
            sec_tick = 1'b0;
            check("auto_inc_after_tick", {31'd0, auto_inc}, 32'd1);
            check("mode_run", {30'd0, mode}, 32'd0);
            cnt_a += int'(auto_inc);
            step(2);
            cnt_a += int'(auto_inc);
        end
        check("auto_inc_count", cnt_a, 32'd3);

        // Enter SET_HR, one inc press while ticks continue
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
        check("mode_set_hr", {30'd0, mode}, 32'd1);
        check("blink_on_entry", {31'd0, blink}, 32'd1);
        step(1);
        btn_inc = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            sec_tick = (i % 2 == 0);
            step(1);
            cnt_a += int'(hr_manual_inc);
            cnt_b += int'(auto_inc);
        end
        btn_inc  = 1'b0;
        sec_tick = 1'b0;
        step(1);
        check("hr_pulse_count", cnt_a, 32'd1);
        check("no_auto_in_set", cnt_b, 32'd0);

        // Same-cycle mode and inc edges in SET_HR
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step(1);
        check("mode_wins", {30'd0, mode}, 32'd2);
        check("inc_dropped", {30'd0, hr_manual_inc, min_manual_inc}, 32'd0);
        step(2);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(2);

        // Auto-repeat in SET_MIN: hold 30 cycles, then released
        want = '{0, 10, 14, 18, 22, 26};
        btn_inc = 1'b1;
        for (int i = 0; i < 42; i++) begin
            if (i == 30) btn_inc = 1'b0;
            step(1);
            if (min_manual_inc === 1'b1) hits.push_back(i);
        end
        check("repeat_pulse_count", hits.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            check("repeat_pulse_cycle", (i < hits.size()) ? hits[i] : -1, want[i]);

        // Back to RUN, then three mode presses from RUN
        press_mode();
        check("mode_back_run", {30'd0, mode}, 32'd0);
        cnt_c = 0;
        clr_on_run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_mode = 1'b1;
            step(1);
            seen[i] = mode;
            cnt_c += int'(sec_clear);
            if (i == 2) clr_on_run = sec_clear;
            btn_mode = 1'b0;
            step(1);
            cnt_c += int'(sec_clear);
        end
        check("mode_seq_0", {30'd0, seen[0]}, 32'd1);
        check("mode_seq_1", {30'd0, seen[1]}, 32'd2);
        check("mode_seq_2", {30'd0, seen[2]}, 32'd0);
        check("sec_clear_count", cnt_c, 32'd1);
        check("sec_clear_on_run", {31'd0, clr_on_run}, 32'd1);

        // Reset while holding btn_inc in SET_MIN; btn_mode held through release
        press_mode();
        press_mode();
        btn_inc = 1'b1;
        step(5);
        reset = 1'b1;
        step(1);
        check("reset_mid_hold",
              {26'd0, auto_inc, min_manual_inc, hr_manual_inc, sec_clear, mode, blink}, 32'd0);
        btn_mode = 1'b1;
        step(2);
        reset = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            cnt_a += int'(min_manual_inc) + int'(hr_manual_inc) + int'(sec_clear);
        end
        check("no_pulse_after_reset", cnt_a, 32'd0);
        check("held_mode_no_edge", {30'd0, mode}, 32'd0);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
